// File: rtl/pdm_stereo_mic_emulator.sv
// pdm_stereo_mic_emulator
//   Turns a stream of stereo 16-bit PCM pairs into one shared PDM data line
//   plus its bit clock. The left bit is driven while mic_clk is high and the
//   right bit while mic_clk is low. Each channel runs its own first-order
//   sigma-delta modulator. A short per-channel delay line lets a virtual
//   source be placed at any beamforming angle.
//
// Ports
//   s_clk        system clock (single domain)
//   rst          synchronous reset, active-high
//   enable       runs the mic_clk divider and the modulators
//   pcm_valid    a PCM pair is offered
//   pcm_ready    the one-entry input buffer is empty
//   l_pcm/r_pcm  signed PCM samples
//   l_delay      left channel bit delay (0 = newest bit)
//   r_delay      right channel bit delay (0 = newest bit)
//   mic_clk      PDM bit clock
//   mic_data     multiplexed PDM data
//   frame_start  one-cycle pulse when a new frame starts
//   underrun     sticky; a frame started with no fresh sample buffered
module pdm_stereo_mic_emulator #(
  parameter int CLK_DIV   = 8,
  parameter int OSR       = 64,
  parameter int MAX_DELAY = 16,
  parameter int PCM_W     = 16
) (
  input  logic                         s_clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         pcm_valid,
  output logic                         pcm_ready,
  input  logic signed [PCM_W-1:0]      l_pcm,
  input  logic signed [PCM_W-1:0]      r_pcm,
  input  logic [$clog2(MAX_DELAY)-1:0] l_delay,
  input  logic [$clog2(MAX_DELAY)-1:0] r_delay,
  output logic                         mic_clk,
  output logic                         mic_data,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
  // Two guard bits: the integrator is bounded by +/-2^PCM_W.
  localparam int IW    = PCM_W + 2;
  localparam logic signed [IW-1:0] FB_MAG =
    {{(IW-PCM_W){1'b0}}, 1'b1, {(PCM_W-1){1'b0}}};

  logic [DIV_W-1:0]          div_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic signed [PCM_W-1:0]   buf_l, buf_r, act_l, act_r;
  logic signed [IW-1:0]      il, ir;
  logic                      ql, qr;
  logic [MAX_DELAY-1:0]      sr_l, sr_r;

  logic                      tick, left_ev, right_ev, boundary, load;
  logic signed [PCM_W-1:0]   x_l;
  logic signed [IW-1:0]      fb_l, fb_r, il_next, ir_next;
  logic                      ql_next, qr_next;
  logic [MAX_DELAY-1:0]      sr_l_next, sr_r_next;

  // Event decode and modulator next-state arithmetic.
  always_comb begin
    tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    left_ev  = enable && tick && !mic_clk;
    right_ev = enable && tick && mic_clk;
    boundary = left_ev && (bit_cnt == '0);
    // pcm_ready low means the buffer holds a pair waiting to be loaded.
    load     = boundary && !pcm_ready;
    // The left modulator sees the freshly loaded sample in the load cycle.
    x_l       = load ? buf_l : act_l;
    fb_l      = ql ? FB_MAG : -FB_MAG;
    fb_r      = qr ? FB_MAG : -FB_MAG;
    il_next   = il + {{2{x_l[PCM_W-1]}}, x_l} - fb_l;
    ir_next   = ir + {{2{act_r[PCM_W-1]}}, act_r} - fb_r;
    ql_next   = ~il_next[IW-1];
    qr_next   = ~ir_next[IW-1];
    sr_l_next = {sr_l[MAX_DELAY-2:0], ql_next};
    sr_r_next = {sr_r[MAX_DELAY-2:0], qr_next};
  end

  // Divider, modulators, delay lines, input buffer and status outputs.
  always_ff @(posedge s_clk) begin
    if (rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      mic_clk     <= 1'b0;
      mic_data    <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      pcm_ready   <= 1'b1;
      buf_l       <= '0;
      buf_r       <= '0;
      act_l       <= '0;
      act_r       <= '0;
      il          <= '0;
      ir          <= '0;
      ql          <= 1'b0;
      qr          <= 1'b0;
      sr_l        <= '0;
      sr_r        <= '0;
    end else begin
      frame_start <= 1'b0;

      if (enable) begin
        if (tick) begin
          div_cnt <= '0;
          mic_clk <= ~mic_clk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
        mic_clk <= 1'b0;
      end

      if (left_ev) begin
        il       <= il_next;
        ql       <= ql_next;
        sr_l     <= sr_l_next;
        mic_data <= sr_l_next[l_delay];
        bit_cnt  <= (bit_cnt == BIT_W'(OSR - 1)) ? '0 : bit_cnt + BIT_W'(1);
        if (boundary) begin
          frame_start <= 1'b1;
          if (load) begin
            act_l <= buf_l;
            act_r <= buf_r;
          end else begin
            underrun <= 1'b1;
          end
        end
      end

      if (right_ev) begin
        ir       <= ir_next;
        qr       <= qr_next;
        sr_r     <= sr_r_next;
        mic_data <= sr_r_next[r_delay];
      end

      // A load and a transfer are mutually exclusive: load needs ready=0.
      if (load) begin
        pcm_ready <= 1'b1;
      end else if (pcm_valid && pcm_ready) begin
        buf_l     <= l_pcm;
        buf_r     <= r_pcm;
        pcm_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_stereo_mic_emulator.sv
// tb_pdm_stereo_mic_emulator
//   Self-checking bench: a behavioural model (integer sigma-delta arithmetic,
//   bit-history queues, enabled-cycle counting) predicts every output each
//   cycle; directed phases add stream-level checks on top.
module tb_pdm_stereo_mic_emulator;
  localparam int CLK_DIV   = 8;
  localparam int OSR       = 64;
  localparam int MAX_DELAY = 16;
  localparam int PCM_W     = 16;
  localparam int DW        = $clog2(MAX_DELAY);
  localparam int HALF      = 1 << (PCM_W - 1);

  logic s_clk = 1'b0;
  logic rst, enable, pcm_valid, pcm_ready;
  logic signed [PCM_W-1:0] l_pcm, r_pcm;
  logic [DW-1:0] l_delay, r_delay;
  logic mic_clk, mic_data, frame_start, underrun;

  pdm_stereo_mic_emulator #(
    .CLK_DIV(CLK_DIV), .OSR(OSR), .MAX_DELAY(MAX_DELAY), .PCM_W(PCM_W)
  ) dut (
    .s_clk(s_clk), .rst(rst), .enable(enable), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .l_pcm(l_pcm), .r_pcm(r_pcm),
    .l_delay(l_delay), .r_delay(r_delay), .mic_clk(mic_clk),
    .mic_data(mic_data), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 s_clk = ~s_clk;

  int total = 0;
  int bad   = 0;

  // model state
  int m_n, m_bit, m_il, m_ir, m_act_l, m_act_r, m_buf_l, m_buf_r, m_frame;
  bit m_ql, m_qr, m_ready, m_clk, m_data, m_fs, m_under, m_lev, m_rev;
  bit hist_l[$];
  bit hist_r[$];

  // stream statistics gathered from observed DUT data
  int ones_l[4];
  int ones_r[4];
  int cyc, nrise;
  int rise_at[2];
  bit prev_clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sd_step(inout int integ, inout bit q, input int x);
    integ = integ + x - (q ? HALF : -HALF);
    q = (integ >= 0);
  endtask

  function automatic bit pick(input bit h[$], input int idx);
    if (idx < h.size()) return h[idx];
    return 1'b0;
  endfunction

  task automatic model_update();
    bit accept, load;
    m_fs = 0; m_lev = 0; m_rev = 0;
    if (rst) begin
      m_n = 0; m_bit = 0; m_il = 0; m_ir = 0; m_act_l = 0; m_act_r = 0;
      m_buf_l = 0; m_buf_r = 0; m_frame = 0; m_ql = 0; m_qr = 0;
      m_ready = 1; m_clk = 0; m_data = 0; m_under = 0;
      hist_l.delete(); hist_r.delete();
      for (int i = 0; i < 4; i++) begin ones_l[i] = 0; ones_r[i] = 0; end
      return;
    end
    accept = pcm_valid && m_ready;
    load = 0;
    if (enable) begin
      m_n++;
      if (m_n % CLK_DIV == 0) begin
        m_clk = ((m_n / CLK_DIV) % 2) == 1;
        if (m_clk) begin
          m_lev = 1;
          if (m_bit == 0) begin
            m_fs = 1;
            m_frame++;
            if (!m_ready) begin
              load = 1; m_act_l = m_buf_l; m_act_r = m_buf_r;
            end else begin
              m_under = 1;
            end
          end
          sd_step(m_il, m_ql, m_act_l);
          hist_l.push_front(m_ql);
          if (hist_l.size() > MAX_DELAY) void'(hist_l.pop_back());
          m_data = pick(hist_l, int'(l_delay));
          m_bit = (m_bit + 1) % OSR;
        end else begin
          m_rev = 1;
          sd_step(m_ir, m_qr, m_act_r);
          hist_r.push_front(m_qr);
          if (hist_r.size() > MAX_DELAY) void'(hist_r.pop_back());
          m_data = pick(hist_r, int'(r_delay));
        end
      end
    end else begin
      m_n = 0;
      m_clk = 0;
    end
    if (load) m_ready = 1;
    if (accept) begin
      m_buf_l = l_pcm; m_buf_r = r_pcm; m_ready = 0;
    end
  endtask

  task automatic step();
    @(posedge s_clk);
    model_update();
    @(negedge s_clk);
    check_val("mic_clk", mic_clk, m_clk);
    check_val("mic_data", mic_data, m_data);
    check_val("pcm_ready", pcm_ready, m_ready);
    check_val("frame_start", frame_start, m_fs);
    check_val("underrun", underrun, m_under);
    if (m_lev && m_frame >= 1 && m_frame <= 4) ones_l[m_frame-1] += int'(mic_data);
    if (m_rev && m_frame >= 1 && m_frame <= 4) ones_r[m_frame-1] += int'(mic_data);
    cyc++;
    if (mic_clk && !prev_clk) begin
      if (nrise < 2) rise_at[nrise] = cyc;
      nrise++;
    end
    prev_clk = mic_clk;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    check_val("rst_mic_clk", mic_clk, 0);
    check_val("rst_mic_data", mic_data, 0);
    check_val("rst_ready", pcm_ready, 1);
    check_val("rst_underrun", underrun, 0);
    check_val("rst_frame_start", frame_start, 0);
    rst = 1'b0;
    cyc = 0; nrise = 0; prev_clk = 1'b0;
    rise_at[0] = -1; rise_at[1] = -1;
  endtask

  initial begin
    logic signed [PCM_W-1:0] v;
    rst = 1'b1; enable = 1'b1; pcm_valid = 1'b0;
    l_pcm = '0; r_pcm = '0; l_delay = '0; r_delay = '0;
    @(negedge s_clk);

    // zero input, sample always offered
    do_reset();
    pcm_valid = 1'b1;
    repeat (2 * OSR * 2 * CLK_DIV + 20) step();
    check_val("first_rise", rise_at[0], CLK_DIV);
    check_val("second_rise", rise_at[1], 3 * CLK_DIV);
    check_val("zero_l_f1", ones_l[0], 33);
    check_val("zero_l_f2", ones_l[1], 32);
    check_val("zero_r_f1", ones_r[0], 33);
    check_val("zero_r_f2", ones_r[1], 32);
    check_val("no_underrun", underrun, 0);
    enable = 1'b0;
    step();
    check_val("enable_off_clk", mic_clk, 0);
    enable = 1'b1;

    // full-scale inputs
    do_reset();
    l_pcm = 16'sh7FFF; r_pcm = 16'sh8000; pcm_valid = 1'b1;
    repeat (OSR * 2 * CLK_DIV + 60) step();
    check_val("fs_l_ones", ones_l[0], 64);
    check_val("fs_r_ones", ones_r[0], 1);

    // delay: same PCM on both channels, left delayed by 3 then realigned
    do_reset();
    v = PCM_W'($urandom);
    l_pcm = v; r_pcm = v; l_delay = DW'(3); r_delay = '0;
    repeat (OSR * 2 * CLK_DIV + 60) step();
    l_delay = '0;
    repeat (OSR * 2 * CLK_DIV) step();

    // underrun: one sample only
    do_reset();
    l_pcm = PCM_W'($urandom); r_pcm = PCM_W'($urandom);
    pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
    repeat (2 * OSR * 2 * CLK_DIV + 40) step();
    check_val("underrun_set", underrun, 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      l_pcm = PCM_W'($urandom);
      r_pcm = PCM_W'($urandom);
      pcm_valid = ($urandom_range(0, 99) < ((i < 3000) ? 5 : 1));
      if ($urandom_range(0, 199) == 0) l_delay = DW'($urandom);
      if ($urandom_range(0, 199) == 0) r_delay = DW'($urandom);
      enable = ($urandom_range(0, 499) != 0);
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
